if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request and valid response interface.
- Presents pcF, InstF and pc4F to the IF/ID pipeline register.
- Handles stalls from the hazard unit (if_id_regwrite low) and PC redirects from branch/jump resolution, discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction presented on InstF when no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
if_id_regwrite  input  1  IF/ID register captures this cycle (0 = stall).
redirect_valid  input  1  branch taken or jump; redirect PC this cycle.
redirect_pc  input  32  redirect target address.
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  32  fetch address, word aligned.
imem_req_ready  input  1  memory accepts request.
imem_resp_valid  input  1  fetch data returned; at most one outstanding request.
imem_resp_data  input  32  fetched instruction word.
pcF  output  32  PC of the instruction on InstF.
InstF  output  32  instruction to IF/ID; NOP_INST when validF=0.
pc4F  output  32  pcF + 4, modulo 2^32.
validF  output  1  InstF holds a real fetched instruction.

Behaviour:
- State is one of REQ, WAIT, HOLD, DRAIN, plus registers pc[31:0] and inst_q[31:0].
- Reset: pc=RESET_PC, state=REQ, inst_q=NOP_INST, validF=0. Reset overrides all other inputs, including mid-transaction; any response arriving after reset while in REQ is ignored.
- Combinational outputs:
  - imem_req_valid = (state==REQ).
  - imem_req_addr = pc.
  - pcF = pc.
  - pc4F = pc+4 (wraps at 32 bits).
  - validF = (state==HOLD).
  - InstF = validF ? inst_q : NOP_INST.
- Redirect alignment: redirect_pc[1:0] is ignored; pc is loaded with {redirect_pc[31:2],2'b00}.
- Priority at every edge: rst > redirect_valid > normal flow.
- REQ:
  - req handshake (valid&ready), no redirect -> WAIT.
  - redirect with handshake -> pc=target, DRAIN.
  - redirect without handshake -> pc=target, stay REQ. The request address changes; memory must not have latched it.
- WAIT:
  - resp_valid, no redirect -> inst_q=resp_data, HOLD. Earliest validF is 2 cycles after the request handshake.
  - redirect with resp_valid the same cycle -> response discarded, pc=target, REQ.
  - redirect without resp -> pc=target, DRAIN.
- DRAIN:
  - resp_valid -> response discarded, REQ.
  - redirect -> pc=target, state unchanged.
  - Both in the same cycle -> pc=target, REQ.
- HOLD:
  - if_id_regwrite=1, no redirect -> pc=pc+4, REQ.
  - if_id_regwrite=0 -> hold pc, inst_q, validF stable indefinitely.
  - redirect -> pc=target, REQ. Applies regardless of if_id_regwrite; pc+4 increment suppressed.
- if_id_regwrite=1 in REQ/WAIT/DRAIN: IF/ID captures the NOP bubble; fetch state unaffected.
- imem_resp_valid in REQ or HOLD is a protocol error; it is ignored and state is unchanged.
- PC wrap: pc=32'hFFFF_FFFC advancing -> 32'h0000_0000.
- Throughput: one instruction per 3 cycles with 1-cycle memory. No prefetch; exactly one outstanding request.

Test Plan:
1. Reset sequence: rst=1 two cycles then 0, ready=1, memory returns data the cycle after accept -> imem_req_addr=0x0 on the first post-reset cycle; after the response, validF=1, InstF=data, pcF=0x0, pc4F=0x4; with if_id_regwrite=1 the next request address is 0x4.
2. Stall in HOLD: hold if_id_regwrite=0 for 5 cycles with InstF=0x00500093 -> validF, InstF, pcF unchanged and no new request issued. Release -> next request at pcF+4.
3. Redirect during WAIT: request at 0x10 accepted, redirect_pc=0x200 before the response -> DRAIN; the late response 0xDEADBEEF never appears on InstF; the next request address is 0x200.
4. Redirect coincident with response in WAIT -> data dropped, validF stays 0, next request address 0x200. Unaligned redirect_pc=0x203 -> request address 0x200.
5. Redirect in HOLD with if_id_regwrite=0 -> validF falls next cycle, next request address is the target (not pc+4).
6. Reset mid-operation: assert rst while in WAIT; a response arrives the cycle after reset deasserts -> ignored; request at RESET_PC; validF=0.
7. Wrap: redirect to 0xFFFF_FFFC, accept -> pc4F=0x0, next request address 0x0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// Owns the PC, issues one word fetch at a time to instruction memory and
// presents the fetched instruction to the IF/ID pipeline register. It handles
// stalls from the hazard unit and PC redirects from branch/jump resolution.
// A response that belongs to a redirected (stale) fetch is dropped.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   if_id_regwrite    IF/ID captures this cycle (0 = stall)
//   redirect_valid    redirect the PC to redirect_pc this cycle
//   redirect_pc       redirect target (low two bits ignored)
//   imem_req_*        fetch request (valid/ready, word-aligned address)
//   imem_resp_*       fetch response (valid, instruction word)
//   pcF, InstF, pc4F  PC, instruction and PC+4 handed to IF/ID
//   validF            InstF holds a real fetched instruction
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | request for pc is being presented to memory
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction held in inst_q, waiting for IF/ID to take it
// DRAIN | request accepted but redirected; dropping its response

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_id_regwrite,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] pcF,
  output logic [31:0] InstF,
  output logic [31:0] pc4F,
  output logic        validF
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] target_pc;
  logic        req_fire;

  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign req_fire  = (state == S_REQ) && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      inst_q <= NOP_INST;
    end else begin
      case (state)
        S_REQ: begin
          // A redirect without a handshake just retargets the pending request.
          if (redirect_valid) begin
            pc <= target_pc;
            if (req_fire) state <= S_DRAIN;
          end else if (req_fire) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc    <= target_pc;
            // If the stale response lands this same cycle, nothing is left in flight.
            state <= imem_resp_valid ? S_REQ : S_DRAIN;
          end else if (imem_resp_valid) begin
            inst_q <= imem_resp_data;
            state  <= S_HOLD;
          end
        end
        S_DRAIN: begin
          if (redirect_valid) pc <= target_pc;
          if (imem_resp_valid) state <= S_REQ;
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc    <= target_pc;
            state <= S_REQ;
          end else if (if_id_regwrite) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign pcF            = pc;
  assign pc4F           = pc + 32'd4;
  assign validF         = (state == S_HOLD);
  assign InstF          = validF ? inst_q : NOP_INST;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage. Inputs are driven 1 ns after the
// rising edge and outputs are checked at the same point, so each step()
// shows the result of exactly one clock edge.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_regwrite;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] pcF;
  logic [31:0] InstF;
  logic [31:0] pc4F;
  logic        validF;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .if_id_regwrite  (if_id_regwrite),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .pcF             (pcF),
    .InstF           (InstF),
    .pc4F            (pc4F),
    .validF          (validF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_id_regwrite = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;

    // 1. reset and first fetch
    step(); step();
    rst = 1'b0;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_req_addr",  imem_req_addr, 32'h0);
    chk("rst_validF",    32'(validF), 32'd0);
    chk("rst_InstF",     InstF, NOP);
    chk("rst_pcF",       pcF, 32'h0);
    chk("rst_pc4F",      pc4F, 32'h4);
    imem_req_ready = 1'b1;
    step();                                   // accepted -> WAIT
    imem_req_ready = 1'b0;
    chk("t1_wait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t1_wait_validF",    32'(validF), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
    step();                                   // -> HOLD
    imem_resp_valid = 1'b0;
    chk("t1_validF", 32'(validF), 32'd1);
    chk("t1_InstF",  InstF, 32'h0050_0093);
    chk("t1_pcF",    pcF, 32'h0);
    chk("t1_pc4F",   pc4F, 32'h4);

    // 2. stall in HOLD for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_stall_validF",    32'(validF), 32'd1);
      chk("t2_stall_InstF",     InstF, 32'h0050_0093);
      chk("t2_stall_pcF",       pcF, 32'h0);
      chk("t2_stall_req_valid", 32'(imem_req_valid), 32'd0);
    end
    if_id_regwrite = 1'b1;
    step();                                   // -> REQ at pc+4
    if_id_regwrite = 1'b0;
    chk("t2_rel_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t2_rel_req_addr",  imem_req_addr, 32'h4);
    chk("t2_rel_validF",    32'(validF), 32'd0);

    // 3. redirect in REQ without handshake, then redirect during WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("t3_req_redir_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_req_redir_addr",  imem_req_addr, 32'h10);
    imem_req_ready = 1'b1;
    step();                                   // -> WAIT
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();                                   // -> DRAIN
    redirect_valid = 1'b0;
    chk("t3_drain_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t3_drain_validF",    32'(validF), 32'd0);
    chk("t3_drain_InstF",     InstF, NOP);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    step();                                   // stale response dropped -> REQ
    imem_resp_valid = 1'b0;
    chk("t3_InstF",     InstF, NOP);
    chk("t3_validF",    32'(validF), 32'd0);
    chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_req_addr",  imem_req_addr, 32'h200);

    // 4. redirect coincident with response in WAIT, unaligned target
    imem_req_ready = 1'b1;
    step();                                   // -> WAIT
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    step();                                   // -> REQ at 0x200
    redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    chk("t4_validF",    32'(validF), 32'd0);
    chk("t4_InstF",     InstF, NOP);
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_req_addr",  imem_req_addr, 32'h200);
    // stray response in REQ is ignored
    imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_F00D;
    step();
    imem_resp_valid = 1'b0;
    chk("t4_stray_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_stray_req_addr",  imem_req_addr, 32'h200);
    chk("t4_stray_validF",    32'(validF), 32'd0);

    // 5. redirect in HOLD while stalled
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0113;
    step();                                   // -> HOLD
    imem_resp_valid = 1'b0;
    chk("t5_hold_validF", 32'(validF), 32'd1);
    chk("t5_hold_InstF",  InstF, 32'h00A0_0113);
    chk("t5_hold_pcF",    pcF, 32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk("t5_validF",   32'(validF), 32'd0);
    chk("t5_req_addr", imem_req_addr, 32'h300);

    // 6. reset while in WAIT, response right after reset
    imem_req_ready = 1'b1;
    step();                                   // -> WAIT
    imem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0BAD;
    step();
    imem_resp_valid = 1'b0;
    chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_req_addr",  imem_req_addr, 32'h0);
    chk("t6_validF",    32'(validF), 32'd0);
    chk("t6_InstF",     InstF, NOP);

    // DRAIN: redirect alone stays, redirect with response returns to REQ
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();                                   // -> DRAIN
    redirect_pc = 32'h80;
    step();                                   // still DRAIN, pc=0x80
    chk("dr_req_valid", 32'(imem_req_valid), 32'd0);
    chk("dr_pcF",       pcF, 32'h80);
    redirect_pc = 32'hC0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    step();                                   // -> REQ at 0xC0
    redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    chk("dr_both_req_valid", 32'(imem_req_valid), 32'd1);
    chk("dr_both_req_addr",  imem_req_addr, 32'hC0);
    chk("dr_both_validF",    32'(validF), 32'd0);

    // 7. PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("t7_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("t7_pc4F",     pc4F, 32'h0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
    step();                                   // -> HOLD
    imem_resp_valid = 1'b0;
    chk("t7_validF", 32'(validF), 32'd1);
    chk("t7_InstF",  InstF, 32'h0010_0093);
    if_id_regwrite = 1'b1;
    step();
    if_id_regwrite = 1'b0;
    chk("t7_wrap_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t7_wrap_req_addr",  imem_req_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
